// File: rtl/exe_stage.sv
// Execute stage: ALU, data SRAM request and forwarding bus; multiply and the
// restoring divider are built only when EXE_MULDIV_EN is defined.
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
    logic        use_sub;
    logic [32:0] add_sum;
    logic        slt_res, sltu_res;

    assign {op_lui, op_sra, op_srl, op_sll, op_xor, op_or,
            op_nor, op_and, op_sltu, op_slt, op_sub, op_add} = alu_op;

    // One adder serves add, sub and both compares; carry-out low means borrow.
    assign use_sub  = op_sub | op_slt | op_sltu;
    assign add_sum  = {1'b0, alu_src1} + {1'b0, use_sub ? ~alu_src2 : alu_src2} + {32'd0, use_sub};
    assign slt_res  = (alu_src1[31] & ~alu_src2[31]) | (~(alu_src1[31] ^ alu_src2[31]) & add_sum[31]);
    assign sltu_res = ~add_sum[32];

    assign alu_result = ({32{op_add | op_sub}} & add_sum[31:0])
                      | ({32{op_slt}}          & {31'd0, slt_res})
                      | ({32{op_sltu}}         & {31'd0, sltu_res})
                      | ({32{op_and}}          & (alu_src1 & alu_src2))
                      | ({32{op_nor}}          & ~(alu_src1 | alu_src2))
                      | ({32{op_or}}           & (alu_src1 | alu_src2))
                      | ({32{op_xor}}          & (alu_src1 ^ alu_src2))
                      | ({32{op_sll}}          & (alu_src1 << alu_src2[4:0]))
                      | ({32{op_srl}}          & (alu_src1 >> alu_src2[4:0]))
                      | ({32{op_sra}}          & 32'($signed(alu_src1) >>> alu_src2[4:0]))
                      | ({32{op_lui}}          & alu_src2);
endmodule

module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic [162:0] ID_to_EXE_BUS,
    input  logic         ID_to_EXE_valid,
    input  logic         MEM_allowin,
    output logic         EXE_allowin,
    output logic         EXE_to_MEM_valid,
    output logic [74:0]  EXE_to_MEM_BUS,
    output logic [37:0]  EXE_RF_BUS,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] rkd_value;
        logic        mem_en;
        logic [3:0]  mem_we;
        logic [11:0] alu_op;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [3:0]  load_op;
        logic        rfrom_mem;
        logic [6:0]  mul_div_op;
    } id_exe_bus_t;

    id_exe_bus_t exe_bus;
    logic        exe_valid;
    logic        exe_ready_go;
    logic        stall_src;
    logic [31:0] alu_result;
    logic [31:0] result;
    logic [4:0]  exe_dest;

    assign EXE_allowin      = !exe_valid | (exe_ready_go & MEM_allowin);
    assign EXE_to_MEM_valid = exe_valid & exe_ready_go;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_valid <= 1'b0;
        end else if (EXE_allowin) begin
            exe_valid <= ID_to_EXE_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_bus <= '0;
        end else if (ID_to_EXE_valid && EXE_allowin) begin
            exe_bus <= ID_to_EXE_BUS;
        end
    end

    alu u_alu (
        .alu_op    (exe_bus.alu_op),
        .alu_src1  (exe_bus.alu_src1),
        .alu_src2  (exe_bus.alu_src2),
        .alu_result(alu_result)
    );

`ifdef EXE_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t  div_state, div_next;
    logic [4:0]  div_cnt;
    logic [31:0] div_rem, div_quo, div_dvs;

    logic        op_mul_w, op_mulh_w, op_mulh_wu, op_div_w, op_mod_w, op_div_wu, op_mod_wu;
    logic        is_mul, is_div, div_signed, want_rem;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] mul_result;
    logic        src1_neg, src2_neg;
    logic [31:0] src1_mag, src2_mag;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] quo_out, rem_out, md_result;

    assign {op_mul_w, op_mulh_w, op_mulh_wu, op_div_w,
            op_mod_w, op_div_wu, op_mod_wu} = exe_bus.mul_div_op;

    assign is_mul     = op_mul_w | op_mulh_w | op_mulh_wu;
    assign is_div     = op_div_w | op_mod_w | op_div_wu | op_mod_wu;
    assign div_signed = op_div_w | op_mod_w;
    assign want_rem   = op_mod_w | op_mod_wu;

    // Low 64 bits of the product of the extended operands equal the exact
    // signed or unsigned product, so one multiplier serves all three ops.
    assign mul_a      = {{32{op_mulh_w & exe_bus.alu_src1[31]}}, exe_bus.alu_src1};
    assign mul_b      = {{32{op_mulh_w & exe_bus.alu_src2[31]}}, exe_bus.alu_src2};
    assign product    = mul_a * mul_b;
    assign mul_result = op_mul_w ? product[31:0] : product[63:32];

    assign src1_neg = div_signed & exe_bus.alu_src1[31];
    assign src2_neg = div_signed & exe_bus.alu_src2[31];
    assign src1_mag = src1_neg ? -exe_bus.alu_src1 : exe_bus.alu_src1;
    assign src2_mag = src2_neg ? -exe_bus.alu_src2 : exe_bus.alu_src2;

    assign div_shift = {div_rem, div_quo[31]};
    assign div_ge    = div_shift >= {1'b0, div_dvs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_state <= IDLE;
        end else begin
            div_state <= div_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        div_next = div_state;
        case (div_state)
            IDLE:    if (exe_valid && is_div) div_next = BUSY;
            BUSY:    if (div_cnt == 5'd31) div_next = DONE;
            DONE:    if (EXE_to_MEM_valid && MEM_allowin) div_next = IDLE;
            default: div_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 5'd0;
            div_rem <= 32'd0;
            div_quo <= 32'd0;
            div_dvs <= 32'd0;
        end else if (div_state == IDLE && div_next == BUSY) begin
            div_cnt <= 5'd0;
            div_rem <= 32'd0;
            div_quo <= src1_mag;
            div_dvs <= src2_mag;
        end else if (div_state == BUSY) begin
            div_cnt <= div_cnt + 5'd1;
            div_rem <= div_ge ? (div_shift[31:0] - div_dvs) : div_shift[31:0];
            div_quo <= {div_quo[30:0], div_ge};
        end
    end

    always_comb begin
        quo_out = (src1_neg ^ src2_neg) ? -div_quo : div_quo;
        rem_out = src1_neg ? -div_rem : div_rem;
        if (exe_bus.alu_src2 == 32'd0) begin
            quo_out = 32'hFFFF_FFFF;
            rem_out = exe_bus.alu_src1;
        end
    end

    assign md_result    = is_mul ? mul_result : (want_rem ? rem_out : quo_out);
    assign result       = (|exe_bus.mul_div_op) ? md_result : alu_result;
    assign exe_ready_go = !is_div | (div_state == DONE);
    assign stall_src    = exe_valid & (exe_bus.rfrom_mem | (is_div & (div_state != DONE)));
`else
    logic unused_mul_div_op;

    assign unused_mul_div_op = ^exe_bus.mul_div_op;
    assign result            = alu_result;
    assign exe_ready_go      = 1'b1;
    assign stall_src         = exe_valid & exe_bus.rfrom_mem;
`endif

    assign exe_dest       = (exe_valid & exe_bus.gr_we) ? exe_bus.dest : 5'd0;
    assign EXE_RF_BUS     = {exe_dest, stall_src, result};
    assign EXE_to_MEM_BUS = {exe_bus.pc, exe_bus.gr_we, exe_bus.dest, result,
                             exe_bus.rfrom_mem, exe_bus.load_op};

    assign data_sram_en    = exe_valid & (exe_bus.mem_en | exe_bus.rfrom_mem) & MEM_allowin;
    assign data_sram_we    = exe_bus.mem_we & {4{data_sram_en & exe_bus.mem_en}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = exe_bus.rkd_value;
endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: vector table, hand-written pipeline sequences and
// randomized instructions against a behavioural model.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic [162:0] ID_to_EXE_BUS;
    logic         ID_to_EXE_valid;
    logic         MEM_allowin;
    logic         EXE_allowin;
    logic         EXE_to_MEM_valid;
    logic [74:0]  EXE_to_MEM_BUS;
    logic [37:0]  EXE_RF_BUS;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_EXE_BUS   (ID_to_EXE_BUS),
        .ID_to_EXE_valid (ID_to_EXE_valid),
        .MEM_allowin     (MEM_allowin),
        .EXE_allowin     (EXE_allowin),
        .EXE_to_MEM_valid(EXE_to_MEM_valid),
        .EXE_to_MEM_BUS  (EXE_to_MEM_BUS),
        .EXE_RF_BUS      (EXE_RF_BUS),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004, OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND = 12'h010, OP_NOR = 12'h020, OP_OR  = 12'h040, OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL = 12'h100, OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI  = 12'h800;
    localparam logic [6:0]  MD_MUL_W = 7'h40, MD_MULH_W = 7'h20, MD_MULH_WU = 7'h10, MD_DIV_W = 7'h08;
    localparam logic [6:0]  MD_MOD_W = 7'h04, MD_DIV_WU = 7'h02, MD_MOD_WU = 7'h01;
`ifdef EXE_MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [11:0] op;
        logic [6:0]  md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_md;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [162:0] make_bus(input logic [31:0] pc, input logic gr_we,
                                              input logic [4:0] dest, input logic [31:0] rkd,
                                              input logic mem_en, input logic [3:0] mem_we,
                                              input logic [11:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [3:0] load_op,
                                              input logic rfrom, input logic [6:0] md);
        return {pc, gr_we, dest, rkd, mem_en, mem_we, op, a, b, load_op, rfrom, md};
    endfunction

    // Reference behaviour: one-hot opcode semantics in plain integer arithmetic.
    function automatic logic [31:0] model_result(input logic [11:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [6:0] md);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        logic [31:0] r, q, rm;
        sa = a;
        sb = b;
        r  = 32'd0;
        if      (op == OP_ADD)  r = a + b;
        else if (op == OP_SUB)  r = a - b;
        else if (op == OP_SLT)  r = (sa < sb) ? 32'd1 : 32'd0;
        else if (op == OP_SLTU) r = (a < b) ? 32'd1 : 32'd0;
        else if (op == OP_AND)  r = a & b;
        else if (op == OP_NOR)  r = ~(a | b);
        else if (op == OP_OR)   r = a | b;
        else if (op == OP_XOR)  r = a ^ b;
        else if (op == OP_SLL)  r = a << b[4:0];
        else if (op == OP_SRL)  r = a >> b[4:0];
        else if (op == OP_SRA)  r = sa >>> b[4:0];
        else if (op == OP_LUI)  r = b;
        if (MD_ON && md != 7'd0) begin
            sp = longint'(sa) * longint'(sb);
            up = {32'd0, a} * {32'd0, b};
            if (b == 32'd0) begin
                q  = 32'hFFFF_FFFF;
                rm = a;
            end else if (md == MD_DIV_W || md == MD_MOD_W) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q  = 32'h8000_0000;
                    rm = 32'd0;
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                end
            end else begin
                q  = a / b;
                rm = a % b;
            end
            case (md)
                MD_MUL_W:            r = sp[31:0];
                MD_MULH_W:           r = sp[63:32];
                MD_MULH_WU:          r = up[63:32];
                MD_DIV_W, MD_DIV_WU: r = q;
                default:             r = rm;
            endcase
        end
        return r;
    endfunction

    function automatic int model_wait(input logic [6:0] md);
        return (MD_ON && md[3:0] != 4'd0) ? 33 : 0;
    endfunction

    task automatic add_vec(input string name, input logic [11:0] op, input logic [6:0] md,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_md, input logic [31:0] exp_alu);
        vec_t v;
        v = '{name, op, md, a, b, exp_md, exp_alu};
        vecs.push_back(v);
    endtask

    // Issues one instruction into an empty stage, waits for it to become
    // valid toward MEM (bounded) and hands it off.
    task automatic run_instr(input string name, input logic [162:0] bus,
                             input logic [31:0] exp_res, input int exp_wait);
        int n;
        ID_to_EXE_BUS   = bus;
        ID_to_EXE_valid = 1'b1;
        MEM_allowin     = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        n = 0;
        while (!EXE_to_MEM_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, " result"}, EXE_to_MEM_BUS[36:5], exp_res);
        check({name, " wait"}, n, exp_wait);
        tick();
    endtask

    task automatic wait_valid(input string name, input int exp_wait);
        int n;
        n = 0;
        while (!EXE_to_MEM_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, " wait"}, n, exp_wait);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corner [5];
        logic [31:0] exp, a, b;
        logic [11:0] op;
        logic [6:0]  md;
        int          pulses;

        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

        add_vec("add",      OP_ADD,  7'h0,       32'd5,          32'd7,          32'd12,         32'd12);
        add_vec("sub",      OP_SUB,  7'h0,       32'd5,          32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFE);
        add_vec("slt",      OP_SLT,  7'h0,       32'hFFFF_FFFF,  32'd1,          32'd1,          32'd1);
        add_vec("sltu",     OP_SLTU, 7'h0,       32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0);
        add_vec("and",      OP_AND,  7'h0,       32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  32'hF000_F000);
        add_vec("nor",      OP_NOR,  7'h0,       32'd0,          32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF);
        add_vec("or",       OP_OR,   7'h0,       32'h0000_FFFF,  32'h00FF_0000,  32'h00FF_FFFF,  32'h00FF_FFFF);
        add_vec("xor",      OP_XOR,  7'h0,       32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0FF0_0FF0);
        add_vec("sll",      OP_SLL,  7'h0,       32'd1,          32'd31,         32'h8000_0000,  32'h8000_0000);
        add_vec("srl",      OP_SRL,  7'h0,       32'h8000_0000,  32'd31,         32'd1,          32'd1);
        add_vec("sra",      OP_SRA,  7'h0,       32'h8000_0000,  32'd4,          32'hF800_0000,  32'hF800_0000);
        add_vec("lui",      OP_LUI,  7'h0,       32'd0,          32'h1234_5000,  32'h1234_5000,  32'h1234_5000);
        add_vec("div_w",    12'h0,   MD_DIV_W,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'd0);
        add_vec("mod_w",    12'h0,   MD_MOD_W,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'd0);
        add_vec("div_wu0",  12'h0,   MD_DIV_WU,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'd0);
        add_vec("mod_wu0",  12'h0,   MD_MOD_WU,  32'h0000_1234,  32'd0,          32'h0000_1234,  32'd0);
        add_vec("mulh_wu",  12'h0,   MD_MULH_WU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd0);
        add_vec("mulh_w",   12'h0,   MD_MULH_W,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  32'd0);
        add_vec("mul_w",    12'h0,   MD_MUL_W,   32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  32'd0);
        add_vec("div_ovf",  12'h0,   MD_DIV_W,   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
        add_vec("mod_ovf",  12'h0,   MD_MOD_W,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  32'd0);
        add_vec("div_100",  12'h0,   MD_DIV_W,   32'd100,        32'd10,         32'd10,         32'd0);
        add_vec("div_negb", 12'h0,   MD_DIV_W,   32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd0);
        add_vec("mod_negb", 12'h0,   MD_MOD_W,   32'd7,          32'hFFFF_FFFE,  32'd1,          32'd0);

        ID_to_EXE_BUS   = '0;
        ID_to_EXE_valid = 1'b0;
        MEM_allowin     = 1'b1;
        reset           = 1'b1;
        tick();
        tick();
        check("rst allowin",    EXE_allowin,      1);
        check("rst to_mem_vld", EXE_to_MEM_valid, 0);
        check("rst sram_en",    data_sram_en,     0);
        check("rst sram_we",    data_sram_we,     0);
        check("rst rf_dest",    EXE_RF_BUS[37:33], 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            exp = (MD_ON && vecs[i].md != 7'd0) ? vecs[i].exp_md : vecs[i].exp_alu;
            run_instr(vecs[i].name,
                      make_bus(32'h1C00_0000 + 32'(i * 4), 1'b1, 5'd3, 32'd0, 1'b0, 4'd0,
                               vecs[i].op, vecs[i].a, vecs[i].b, 4'd0, 1'b0, vecs[i].md),
                      exp, model_wait(vecs[i].md));
        end

        // Load: forwarding fields, stall source and a read-only SRAM access.
        ID_to_EXE_BUS   = make_bus(32'h1C00_0100, 1'b1, 5'd5, 32'd0, 1'b0, 4'd0,
                                   OP_ADD, 32'h100, 32'd4, 4'h3, 1'b1, 7'd0);
        ID_to_EXE_valid = 1'b1;
        MEM_allowin     = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        check("ld rf_dest",  EXE_RF_BUS[37:33], 5);
        check("ld stall",    EXE_RF_BUS[32],    1);
        check("ld sram_en",  data_sram_en,      1);
        check("ld sram_we",  data_sram_we,      0);
        check("ld addr",     data_sram_addr,    32'h104);
        check("ld load_op",  EXE_to_MEM_BUS[3:0], 3);
        check("ld rfrom",    EXE_to_MEM_BUS[4], 1);
        check("ld pc",       EXE_to_MEM_BUS[74:43], 32'h1C00_0100);
        check("ld bus dest", EXE_to_MEM_BUS[41:37], 5);
        tick();

        // Store held off by MEM for three cycles: exactly one SRAM pulse.
        ID_to_EXE_BUS   = make_bus(32'h1C00_0200, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b1, 4'hF,
                                   OP_ADD, 32'h10, 32'hC, 4'd0, 1'b0, 7'd0);
        ID_to_EXE_valid = 1'b1;
        MEM_allowin     = 1'b0;
        tick();
        ID_to_EXE_valid = 1'b0;
        pulses = 0;
        check("st blocked allowin", EXE_allowin, 0);
        check("st rf_dest no we",   EXE_RF_BUS[37:33], 0);
        for (int i = 0; i < 3; i++) begin
            pulses += int'(data_sram_en);
            tick();
        end
        MEM_allowin = 1'b1;
        #1;
        check("st sram_we",    data_sram_we,    4'hF);
        check("st addr",       data_sram_addr,  32'h1C);
        check("st wdata",      data_sram_wdata, 32'hDEAD_BEEF);
        pulses += int'(data_sram_en);
        tick();
        for (int i = 0; i < 3; i++) begin
            pulses += int'(data_sram_en);
            tick();
        end
        check("st pulses", pulses, 1);

        // Divide held in DONE by MEM, then a back-to-back divide.
        ID_to_EXE_BUS   = make_bus(32'h1C00_0300, 1'b1, 5'd9, 32'd0, 1'b0, 4'd0,
                                   OP_ADD, 32'hFFFF_FFF9, 32'd2, 4'd0, 1'b0, MD_DIV_W);
        ID_to_EXE_valid = 1'b1;
        MEM_allowin     = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        check("div stall busy", EXE_RF_BUS[32], MD_ON ? 32'd1 : 32'd0);
        MEM_allowin = 1'b0;
        wait_valid("div hold", model_wait(MD_DIV_W));
        exp = model_result(OP_ADD, 32'hFFFF_FFF9, 32'd2, MD_DIV_W);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("div hold valid",  EXE_to_MEM_valid,     1);
            check("div hold result", EXE_to_MEM_BUS[36:5], exp);
        end
        check("div done stall", EXE_RF_BUS[32], 0);
        ID_to_EXE_BUS   = make_bus(32'h1C00_0304, 1'b1, 5'd10, 32'd0, 1'b0, 4'd0,
                                   OP_ADD, 32'd100, 32'd10, 4'd0, 1'b0, MD_DIV_W);
        ID_to_EXE_valid = 1'b1;
        MEM_allowin     = 1'b1;
        #1;
        check("b2b allowin", EXE_allowin, 1);
        tick();
        ID_to_EXE_valid = 1'b0;
        wait_valid("b2b div", model_wait(MD_DIV_W));
        check("b2b result", EXE_to_MEM_BUS[36:5], model_result(OP_ADD, 32'd100, 32'd10, MD_DIV_W));
        tick();

        // Reset arriving at divide iteration 10.
        ID_to_EXE_BUS   = make_bus(32'h1C00_0400, 1'b1, 5'd11, 32'd0, 1'b0, 4'd0,
                                   OP_ADD, 32'hFFFF_FFF9, 32'd2, 4'd0, 1'b0, MD_DIV_W);
        ID_to_EXE_valid = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        repeat (11) tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid rst to_mem_vld", EXE_to_MEM_valid, 0);
        check("mid rst allowin",    EXE_allowin,      1);
        check("mid rst stall",      EXE_RF_BUS[32],   0);
        check("mid rst rf_dest",    EXE_RF_BUS[37:33], 0);
        check("mid rst sram_en",    data_sram_en,     0);
        tick();
        reset = 1'b0;
        tick();
        run_instr("post rst div",
                  make_bus(32'h1C00_0500, 1'b1, 5'd12, 32'd0, 1'b0, 4'd0,
                           OP_ADD, 32'd100, 32'd10, 4'd0, 1'b0, MD_DIV_W),
                  model_result(OP_ADD, 32'd100, 32'd10, MD_DIV_W), model_wait(MD_DIV_W));

        for (int i = 0; i < 40; i++) begin
            op = 12'b1 << $urandom_range(0, 11);
            md = 7'd0;
            if ($urandom_range(0, 2) == 0) md = 7'b1 << $urandom_range(0, 6);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            run_instr("rand",
                      make_bus($urandom, 1'b1, 5'd1, $urandom, 1'b0, 4'd0, op, a, b, 4'd0, 1'b0, md),
                      model_result(op, a, b, md), model_wait(md));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
